spi_reg_responder: RTL
======================

Name: spi_reg_responder

Overview:
- SPI mode-0 responder that lets an external host MCU on the GPIO header read and write a small bank of 8-bit control/status registers inside the FPGA.
- It is the target-side counterpart to the initiator-style serial links the top level drives (e.g. the ADC link).
- It sits between the GPIO_0_D pins and the top-level logic. Writable registers drive LEDs and control bits; read-only registers expose SW, KEY and an ID byte.
- SCLK, CS_N and MOSI are oversampled on CLOCK_50. No second clock domain.

Parameters:
- ADDR_W, 4, register address width; bank depth is 2**ADDR_W.
- ID_VALUE, 8'hA5, constant returned at address 0.
- RESET_VAL, 8'h00, reset value of every writable register.

Ports:
- CLOCK_50  input  1  system clock, 50 MHz.
- RESET  input  1  asynchronous, active-high reset.
- spi_sclk  input  1  host serial clock, async.
- spi_cs_n  input  1  host chip select, active low, async.
- spi_mosi  input  1  host data out, async.
- spi_miso  output  1  responder data out.
- spi_miso_oe  output  1  MISO output enable; top level tri-states the pin when this is low.
- status_in  input  8  sampled value returned at address 1, read-only.
- regs_out  output  8*2**ADDR_W  flattened bank; register n occupies bits [8n+7:8n].
- wr_strobe  output  1  one-cycle pulse on each committed write.
- wr_addr  output  ADDR_W  address of the last committed write.

Behaviour:
- Interface is fixed: one clock (CLOCK_50); RESET is asynchronous and active-high.
- Input synchronisation:
  - spi_sclk, spi_cs_n and spi_mosi each pass through a 2-FF synchroniser plus a third FF for edge detection.
  - The host must keep SCLK at or below CLOCK_50/8 (6.25 MHz).
- Frame format: 16 bits, MSB first, sampled on SCLK rising edge.
  - Bit 15: 1 = read, 0 = write.
  - Bits 14:8: address; bits above ADDR_W are ignored.
  - Bits 7:0: write data (don't-care on reads).
- MISO timing:
  - Changes only on detected SCLK falling edges.
  - Before the 8th falling edge, MISO drives 0.
  - On reads, the selected register byte is captured when the 8th rising edge is detected, then shifted out MSB first starting at the 8th falling edge.
  - On writes, MISO stays 0.
- State machine:
  - IDLE: CS_N high.
  - CS_N falling → CMD; bit counter cleared.
  - CMD: after 8 rising edges → DATA.
  - DATA: after 8 rising edges → COMMIT.
  - COMMIT: one cycle; for a write to a writable address, update the register, pulse wr_strobe and load wr_addr. Then → DONE.
  - DONE: further SCLK edges are ignored until CS_N rises → IDLE.
- Register map:
  - Address 0 = ID_VALUE, read-only.
  - Address 1 = status_in, sampled when the 8th rising edge is detected; read-only.
  - Addresses 2 and up are read/write.
  - Writes to 0 or 1 are discarded with no wr_strobe.
  - regs_out bytes for addresses 0 and 1 are driven with ID_VALUE and status_in.
- Abort: CS_N rising in any state other than DONE returns to IDLE immediately with no commit and no wr_strobe. Registers are unchanged.
- spi_miso_oe is high only while the synchronised CS_N is low.
- Reset values:
  - Writable registers = RESET_VAL.
  - spi_miso = 0, spi_miso_oe = 0, wr_strobe = 0, wr_addr = 0.
  - FSM = IDLE, counters = 0.
- RESET asserted mid-frame aborts the frame. After release, the FSM waits for a fresh CS_N falling edge; a CS_N already low at release is treated as IDLE until it goes high.
- Latency: wr_strobe asserts 4–5 CLOCK_50 cycles after the 16th SCLK rising edge at the pin (synchroniser, edge detect, COMMIT).

Optional Feature:
- Macro: SPI_AUTOINC_EN.
- Defined:
  - DONE is replaced by a burst path: if CS_N stays low after COMMIT, the address increments modulo 2**ADDR_W and the FSM returns to DATA.
  - Each further 8 bits form another data byte, which is written (write frames) or shifted out (read frames) for the incremented address.
  - Read bytes are captured when the last rising edge of the previous byte is detected.
- Undefined: DONE behaviour as above; one register per frame.

Decomposition:
- Shared package spi_reg_pkg holds:
  - FSM state encoding (IDLE, CMD, DATA, COMMIT, DONE).
  - Frame field positions (RW_BIT=15, ADDR_MSB=14, ADDR_LSB=8).
  - Reserved addresses ADDR_ID=0, ADDR_STATUS=1.
  - SCLK_MAX_DIV=8.
- One sub-module is natural: spi_in_sync, a 3-FF synchroniser with rising/falling pulse outputs, instantiated three times.

Test Plan:
- Reset then read address 0 (frame 16'h80xx) → MISO byte 8'hA5; regs_out writable bytes all 8'h00.
- Write 8'h3C to address 2 (16'h023C) → one wr_strobe, wr_addr=2, regs_out[23:16]=8'h3C; subsequent read of address 2 returns 8'h3C.
- status_in=8'h5A, read address 1 → MISO 8'h5A; write 8'hFF to address 1 → no wr_strobe, read still 8'h5A.
- Write 16'h0377 with CS_N raised after 12 bits → no wr_strobe, register 3 unchanged; next full frame to address 3 succeeds.
- RESET pulsed after 10 bits of a write to address 4 holding 8'h99 → all outputs at reset values, register 4 = 8'h00; host must restart with CS_N high then low.
- With SPI_AUTOINC_EN: write frame to address 14 with data 8'h11, 8'h22, 8'h33 in one CS_N → registers 14=8'h11, 15=8'h22; address 0 write discarded (wrap, read-only); exactly two wr_strobes.

Source files
------------

// File: rtl/spi_reg_pkg.sv
// spi_reg_pkg: shared FSM encoding and frame layout
// for the SPI register responder.
package spi_reg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_COMMIT,
    ST_DONE
  } spi_state_t;

  localparam int RW_BIT       = 15;
  localparam int ADDR_MSB     = 14;
  localparam int ADDR_LSB     = 8;
  localparam int ADDR_ID      = 0;
  localparam int ADDR_STATUS  = 1;
  localparam int SCLK_MAX_DIV = 8;

endpackage

// File: rtl/spi_in_sync.sv
// spi_in_sync: 2-FF synchroniser plus an edge FF,
// giving the synced level and rise/fall pulses.
module spi_in_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [2:0] sr_q;

  // shift the async pin through three flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q <= 3'b000;
    end else begin
      sr_q <= {sr_q[1:0], d_i};
    end
  end

  assign sync_o = sr_q[1];
  assign rise_o = sr_q[1] & ~sr_q[2];
  assign fall_o = ~sr_q[1] & sr_q[2];

endmodule

// File: rtl/spi_reg_responder.sv
// spi_reg_responder: SPI mode-0 target exposing an
// 8-bit register bank. SPI_AUTOINC_EN enables bursts.
module spi_reg_responder
  import spi_reg_pkg::*;
#(
  parameter int          ADDR_W    = 4,
  parameter logic [7:0]  ID_VALUE  = 8'hA5,
  parameter logic [7:0]  RESET_VAL = 8'h00
) (
  input  logic CLOCK_50,
  input  logic RESET,
  input  logic spi_sclk,
  input  logic spi_cs_n,
  input  logic spi_mosi,
  output logic spi_miso,
  output logic spi_miso_oe,
  input  logic [7:0] status_in,
  output logic [8*(2**ADDR_W)-1:0] regs_out,
  output logic wr_strobe,
  output logic [ADDR_W-1:0] wr_addr
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int CA_LSB = ADDR_LSB - 8;
  localparam int RW_POS = RW_BIT - 8;
  localparam logic [ADDR_W-1:0] FIRST_RW =
    ADDR_W'(ADDR_STATUS + 1);

  logic sclk_s, sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall;
  logic mosi_s, mosi_rise, mosi_fall;
  logic unused_mosi_edges;

  spi_in_sync u_sclk (
    .clk    (CLOCK_50),
    .rst    (RESET),
    .d_i    (spi_sclk),
    .sync_o (sclk_s),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  spi_in_sync u_cs (
    .clk    (CLOCK_50),
    .rst    (RESET),
    .d_i    (spi_cs_n),
    .sync_o (cs_s),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  spi_in_sync u_mosi (
    .clk    (CLOCK_50),
    .rst    (RESET),
    .d_i    (spi_mosi),
    .sync_o (mosi_s),
    .rise_o (mosi_rise),
    .fall_o (mosi_fall)
  );

  assign unused_mosi_edges =
    ^{mosi_rise, mosi_fall, sclk_s};

  spi_state_t        state_q;
  logic [2:0]        cnt_q;
  logic [7:0]        shift_q;
  logic [7:0]        tx_q;
  logic              rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic              armed_q;
  logic              miso_q;
  logic              oe_q;
  logic              strobe_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [7:0]        regs_q [DEPTH];

  logic [7:0]        byte_d;
  logic [ADDR_W-1:0] cmd_addr_d;
  logic [ADDR_W-1:0] next_addr_d;
  logic [7:0]        bank [DEPTH];

  assign byte_d      = {shift_q[6:0], mosi_s};
  assign cmd_addr_d  = byte_d[CA_LSB +: ADDR_W];
  assign next_addr_d = addr_q + ADDR_W'(1);

  // read view of the bank: ID, live status, storage
  for (genvar g = 0; g < DEPTH; g++) begin : g_bank
    if (g == ADDR_ID) begin : g_id
      assign bank[g] = ID_VALUE;
    end else if (g == ADDR_STATUS) begin : g_st
      assign bank[g] = status_in;
    end else begin : g_rw
      assign bank[g] = regs_q[g];
    end
    assign regs_out[8*g +: 8] = bank[g];
  end

  // frame FSM, shifters and register bank
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 3'd0;
      shift_q   <= 8'h00;
      tx_q      <= 8'h00;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      armed_q   <= 1'b0;
      miso_q    <= 1'b0;
      oe_q      <= 1'b0;
      strobe_q  <= 1'b0;
      wr_addr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= RESET_VAL;
      end
    end else begin
      strobe_q <= 1'b0;
      oe_q     <= ~cs_s & armed_q;
      if (cs_rise) begin
        armed_q <= 1'b1;
      end
      if (cs_rise) begin
        state_q <= ST_IDLE;
        cnt_q   <= 3'd0;
        miso_q  <= 1'b0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            miso_q <= 1'b0;
            if (cs_fall && armed_q) begin
              state_q <= ST_CMD;
              cnt_q   <= 3'd0;
              tx_q    <= 8'h00;
            end
          end
          ST_CMD: begin
            if (sclk_rise) begin
              shift_q <= byte_d;
              cnt_q   <= cnt_q + 3'd1;
              if (cnt_q == 3'd7) begin
                rw_q    <= byte_d[RW_POS];
                addr_q  <= cmd_addr_d;
                tx_q    <= byte_d[RW_POS] ?
                           bank[cmd_addr_d] : 8'h00;
                state_q <= ST_DATA;
              end
            end
          end
          ST_DATA: begin
            if (sclk_fall) begin
              miso_q <= tx_q[7];
              tx_q   <= {tx_q[6:0], 1'b0};
            end
            if (sclk_rise) begin
              shift_q <= byte_d;
              cnt_q   <= cnt_q + 3'd1;
              if (cnt_q == 3'd7) begin
                state_q <= ST_COMMIT;
`ifdef SPI_AUTOINC_EN
                tx_q <= rw_q ?
                        bank[next_addr_d] : 8'h00;
`endif
              end
            end
          end
          ST_COMMIT: begin
            if (!rw_q && addr_q >= FIRST_RW) begin
              regs_q[addr_q] <= shift_q;
              strobe_q       <= 1'b1;
              wr_addr_q      <= addr_q;
            end
`ifdef SPI_AUTOINC_EN
            addr_q  <= next_addr_d;
            cnt_q   <= 3'd0;
            state_q <= ST_DATA;
`else
            state_q <= ST_DONE;
`endif
          end
          ST_DONE: begin
            state_q <= ST_DONE;
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = oe_q;
  assign wr_strobe   = strobe_q;
  assign wr_addr     = wr_addr_q;

endmodule
